// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain and its controller.
package scan_pkg;

    // Default chain length; scan_chain and scan_chain_ctrl both default to this.
    localparam int DEF_CHAIN_LEN = 4;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StShift   = 3'd1,
        StCapture = 3'd2,
        StUnload  = 3'd3,
        StDone    = 3'd4
    } scan_state_e;

endpackage

// File: rtl/scan_bit_counter.sv
// Bit counter shared by the shift-in and unload phases.
// Counts 0..LAST while enabled, wraps to 0 after LAST, and flags LAST on tc.
module scan_bit_counter #(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned LAST  = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LastVal = CNT_W'(LAST);

    logic [CNT_W-1:0] cnt;

    // Count register: clear has priority, wrap on terminal count.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

    assign tc = (cnt == LastVal);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: loads a parallel pattern serially into the chain,
// performs one functional capture cycle, then unloads the response serially
// and presents it as a parallel word.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter  int CHAIN_LEN = DEF_CHAIN_LEN,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic [CHAIN_LEN-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy
);

    scan_state_e          state;
    logic [CHAIN_LEN-1:0] pat_q;
    logic                 cnt_en;
    logic                 cnt_tc;

    // The counter runs only while bits are moving through the chain.
    assign cnt_en = (state == StShift) || (state == StUnload);

    scan_bit_counter #(
        .CNT_W (CNT_W),
        .LAST  (CHAIN_LEN - 1)
    ) u_cnt (
        .clk (clk),
        .clr (rst),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    assign pat_ready = (state == StIdle);
    assign busy      = (state != StIdle);

    // Sequencer with registered chain controls and response word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            scan_en    <= 1'b0;
            scan_in    <= 1'b0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
            pat_q      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pat_valid) begin
                        // Bit 0 goes out immediately; the remainder waits in pat_q.
                        scan_in <= pat_data[0];
                        pat_q   <= pat_data >> 1;
                        scan_en <= 1'b1;
                        state   <= StShift;
                    end
                end
                StShift: begin
                    if (cnt_tc) begin
                        scan_en <= 1'b0;
                        scan_in <= 1'b0;
                        state   <= StCapture;
                    end else begin
                        scan_in <= pat_q[0];
                        pat_q   <= pat_q >> 1;
                    end
                end
                StCapture: begin
                    scan_en <= 1'b1;
                    scan_in <= 1'b0;
                    state   <= StUnload;
                end
                StUnload: begin
                    // First bit out is the flop that received pat_data[0]; shift
                    // in from the top so it lands in bit 0 after CHAIN_LEN samples.
                    resp_data <= {scan_out, resp_data[CHAIN_LEN-1:1]};
                    if (cnt_tc) begin
                        scan_en    <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= StDone;
                    end
                end
                StDone: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl with a 4-flop inverting-capture chain model.
module tb_scan_chain_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pat_data;
    logic         pat_valid;
    logic         pat_ready;
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;
    logic [N-1:0] resp_data;
    logic         resp_valid;
    logic         resp_ready;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scan_chain_ctrl #(
        .CHAIN_LEN (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pat_data   (pat_data),
        .pat_valid  (pat_valid),
        .pat_ready  (pat_ready),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    // Chain model: shift toward the last flop when enabled, else capture the inverse.
    logic [N-1:0] chain_q = '0;
    always_ff @(posedge clk) begin
        if (scan_en) chain_q <= {chain_q[N-2:0], scan_in};
        else         chain_q <= ~chain_q;
    end
    assign scan_out = chain_q[N-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one pattern from IDLE. noise: 0 none, 1 random pat_valid pulses while busy,
    // 2 a 4'b1111 pulse during unload. hold: cycles resp_ready stays low in DONE.
    task automatic run_pattern(input logic [N-1:0] pat, input int hold, input int noise);
        logic [N-1:0] exp_resp;
        // Capture inverts each flop, and resp bit i maps back to pat bit i.
        exp_resp   = ~pat;
        pat_data   = pat;
        pat_valid  = 1'b1;
        resp_ready = 1'b0;
        check("idle_ready", 32'(pat_ready), 32'(1));
        step();  // acceptance edge
        pat_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("shift_en", 32'(scan_en), 32'(1));
            check("shift_in", 32'(scan_in), 32'(pat[k]));
            check("shift_ready", 32'(pat_ready), 32'(0));
            if (noise == 1 && $urandom_range(0, 1) == 1) begin
                pat_valid = 1'b1;
                pat_data  = N'($urandom);
            end else begin
                pat_valid = 1'b0;
            end
            step();
        end
        check("cap_en", 32'(scan_en), 32'(0));
        check("cap_in", 32'(scan_in), 32'(0));
        check("cap_busy", 32'(busy), 32'(1));
        step();
        for (int k = 0; k < N; k++) begin
            check("unl_en", 32'(scan_en), 32'(1));
            check("unl_in", 32'(scan_in), 32'(0));
            check("unl_valid", 32'(resp_valid), 32'(0));
            if (noise == 2 || (noise == 1 && $urandom_range(0, 1) == 1)) begin
                pat_valid = 1'b1;
                pat_data  = (noise == 2) ? '1 : N'($urandom);
            end else begin
                pat_valid = 1'b0;
            end
            step();
        end
        pat_valid = 1'b0;
        // 2N+1 edges after the accepting edge (10th cycle counting the acceptance cycle).
        check("resp_valid", 32'(resp_valid), 32'(1));
        check("resp_data", 32'(resp_data), 32'(exp_resp));
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_data", 32'(resp_data), 32'(exp_resp));
            check("hold_valid", 32'(resp_valid), 32'(1));
            check("hold_en", 32'(scan_en), 32'(0));
            check("hold_in", 32'(scan_in), 32'(0));
            check("hold_ready", 32'(pat_ready), 32'(0));
        end
        resp_ready = 1'b1;
        step();  // response handshake edge
        resp_ready = 1'b0;
        check("post_valid", 32'(resp_valid), 32'(0));
        check("post_ready", 32'(pat_ready), 32'(1));
        check("post_busy", 32'(busy), 32'(0));
    endtask

    // Bounded wait for resp_valid; an expired budget counts as a failure.
    task automatic wait_resp(input string tag);
        int n;
        n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check(tag, 32'(0), 32'(1));
    endtask

    initial begin
        rst        = 1'b1;
        pat_data   = '0;
        pat_valid  = 1'b0;
        resp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_en", 32'(scan_en), 32'(0));
        check("rst_in", 32'(scan_in), 32'(0));
        check("rst_valid", 32'(resp_valid), 32'(0));
        check("rst_data", 32'(resp_data), 32'(0));
        check("rst_ready", 32'(pat_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));

        // Basic and backpressure.
        run_pattern(4'b1011, 0, 0);
        run_pattern(4'b1011, 7, 0);

        // Back-to-back with resp_ready tied high.
        resp_ready = 1'b1;
        pat_valid  = 1'b1;
        pat_data   = 4'b0000;
        step();
        pat_data = 4'b1111;
        wait_resp("b2b_timeout1");
        check("b2b_resp1", 32'(resp_data), 32'(4'b1111));
        step();  // handshake
        check("b2b_ready", 32'(pat_ready), 32'(1));
        step();  // second acceptance
        pat_valid = 1'b0;
        check("b2b_accept", 32'(busy), 32'(1));
        check("b2b_in0", 32'(scan_in), 32'(1));
        wait_resp("b2b_timeout2");
        check("b2b_resp2", 32'(resp_data), 32'(4'b0000));
        step();
        resp_ready = 1'b0;
        check("b2b_idle", 32'(pat_ready), 32'(1));

        // Reset in the second SHIFT cycle.
        pat_valid = 1'b1;
        pat_data  = 4'b1100;
        step();
        pat_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_en", 32'(scan_en), 32'(0));
        check("mrst_in", 32'(scan_in), 32'(0));
        check("mrst_valid", 32'(resp_valid), 32'(0));
        check("mrst_ready", 32'(pat_ready), 32'(1));
        run_pattern(4'b0110, 0, 0);

        // Ignored pattern offer during unload.
        run_pattern(4'b1010, 0, 2);

        // Randomized patterns, stalls and stray offers.
        for (int i = 0; i < 8; i++) begin
            run_pattern(N'($urandom), int'($urandom_range(0, 5)), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Upstream driver for the scan_chain block. Accepts one parallel test pattern via valid/ready.
- Shifts the pattern serially into the chain with scan_en=1, then drops scan_en for one functional capture cycle.
- Shifts the captured response back out and presents it as a parallel word via valid/ready.
- Owns scan_en and scan_in for the chain and consumes the chain's serial output.

Parameters:
- CHAIN_LEN, 4, number of flops in the attached scan chain; legal range 2..64.
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock, shared with scan_chain.
- rst  input  1  synchronous reset, active-high.
- pat_data  input  CHAIN_LEN  pattern to load; bit 0 is shifted first.
- pat_valid  input  1  pattern offered.
- pat_ready  output  1  controller can accept a pattern.
- scan_en  output  1  chain mode select: 1 = shift, 0 = functional/capture.
- scan_in  output  1  serial data into the chain.
- scan_out  input  1  serial data from the last chain flop.
- resp_data  output  CHAIN_LEN  unloaded response; resp_data[i] is the captured value of the flop that held pat_data[i].
- resp_valid  output  1  response available.
- resp_ready  input  1  response consumer ready.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Outputs: all are registered except pat_ready and busy, which are decoded from the state register.
- Reset: while rst is high at a clock edge, the next state is IDLE and:
  - scan_en=0, scan_in=0
  - resp_data=0, resp_valid=0
  - pat_ready=1, busy=0
  - bit counter = 0
- Reset mid-operation: aborts any shift, capture or unload. No partial response is ever presented.
- FSM states: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE:
  - pat_ready=1, scan_en=0, scan_in=0.
  - On pat_valid && pat_ready, latch pat_data into the shift register and go to SHIFT.
- SHIFT (exactly CHAIN_LEN cycles):
  - scan_en=1.
  - scan_in = pat_data[k] in the k-th SHIFT cycle, k = 0..CHAIN_LEN-1.
  - Counter counts 0..CHAIN_LEN-1; at terminal count go to CAPTURE.
- CAPTURE (exactly 1 cycle): scan_en=0, scan_in=0. The chain loads its functional D inputs.
- UNLOAD (exactly CHAIN_LEN cycles):
  - scan_en=1, scan_in=0 (chain is flushed with zeros).
  - At each edge, sample scan_out into resp bit k for the k-th UNLOAD cycle. The first sample is taken at the first UNLOAD edge, before any shift has moved data.
  - At terminal count, go to DONE with resp_valid=1.
- DONE:
  - scan_en=0, resp_valid=1.
  - resp_data is held stable until resp_valid && resp_ready, then go to IDLE with resp_valid=0.
- Latency: scan_en rises in the cycle after pat handshake acceptance. resp_valid rises 2*CHAIN_LEN+1 cycles after scan_en first rises (2*CHAIN_LEN+2 cycles after acceptance).
- Backpressure: pat_ready=0 in every state but IDLE. A held-off resp_ready stalls in DONE indefinitely with no change to scan_en or scan_in.
- Simultaneous events:
  - resp handshake in DONE moves to IDLE; pat_ready rises the next cycle. There is no same-cycle pattern pass-through.
  - pat_valid while busy is ignored and must be held by the producer.
- Counter: wraps to 0 on each SHIFT→CAPTURE and UNLOAD→DONE transition; it is never compared beyond CHAIN_LEN-1.
- scan_in must be glitch-free (registered) because it feeds the chain's D path directly.

Decomposition:
- Shared package scan_pkg:
  - state enum encoding (IDLE, SHIFT, CAPTURE, UNLOAD, DONE)
  - default CHAIN_LEN constant, so scan_chain and this controller agree on length.
- One natural sub-module: scan_bit_counter, a CNT_W-bit counter with clear, enable and terminal-count output, reused by SHIFT and UNLOAD.
- Pattern and response shift registers stay inline.

Test Plan:
- Bench setup: CHAIN_LEN=4, controller connected to a 4-flop scan_chain model whose capture loads the bitwise inverse of its current contents.
- Basic: reset, then pat_data=4'b1011 with pat_valid -> scan_in sequence 1,1,0,1 with scan_en=1 for 4 cycles, one scan_en=0 cycle, 4 unload cycles, then resp_data=4'b0100 and resp_valid=1 exactly 10 cycles after acceptance.
- Backpressure: resp_ready=0 for 7 cycles in DONE -> resp_data stays 4'b0100, scan_en=0, pat_ready=0 throughout; one cycle after resp_ready=1 is sampled, pat_ready=1.
- Back-to-back: patterns 4'b0000 then 4'b1111 offered continuously, resp_ready tied 1 -> responses 4'b1111 then 4'b0000 in order; second acceptance exactly 1 cycle after the first response handshake.
- Reset mid-SHIFT: assert rst in the 2nd SHIFT cycle -> next cycle scan_en=0, scan_in=0, resp_valid=0, pat_ready=1; a following pattern 4'b0110 yields resp_data=4'b1001.
- Ignored input: pulse pat_valid with 4'b1111 during UNLOAD -> no effect; the in-flight response from 4'b1010 is 4'b0101.
